meas_sig_gen: RTL and testbench

Programmable periodic pulse source that drives the comparator-side signal consumed by the strobe generator / period-measurement path. It emits a pulse train of configurable period and high-width on `sig_o` (in clock cycles), with a valid/ready configuration handshake and glitch-free reconfiguration at period boundaries. It serves as the on-chip stimulus for calibrating and self-testing the measure unit.

---
 rtl/meas_pkg.sv | 26 ++
 rtl/meas_sig_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_meas_sig_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_pkg.sv
// meas_pkg: shared types and default widths for the measure-unit stimulus source.
// The optional burst feature of meas_sig_gen is enabled with MEAS_SIG_GEN_BURST_EN.
package meas_pkg;

    // Default counter/config widths.
    localparam int unsigned SG_T_CNT_WIDTH = 32;
    localparam int unsigned SG_W_CNT_WIDTH = 16;
    localparam int unsigned SG_B_CNT_WIDTH = 16;

    // Smallest legal period: one HIGH cycle plus one LOW cycle.
    localparam int unsigned SG_MIN_PERIOD = 2;

    // Pulse generator FSM states.
    typedef enum logic [1:0] {
        SG_IDLE = 2'd0,
        SG_HIGH = 2'd1,
        SG_LOW  = 2'd2
    } sg_state_e;

    // Pulse configuration at default widths.
    typedef struct packed {
        logic [SG_T_CNT_WIDTH-1:0] period;
        logic [SG_W_CNT_WIDTH-1:0] width;
    } sg_cfg_t;

endpackage

// File: rtl/meas_sig_gen.sv
// meas_sig_gen: programmable periodic pulse source used as on-chip stimulus for the
// measure unit. A valid/ready handshake fills a shadow register; the shadow is copied
// into the active config only while idle or at the last LOW cycle of a period, so the
// output never glitches. Define MEAS_SIG_GEN_BURST_EN to enable the burst counter
// (run stops after burst_len_i pulses); otherwise generation is continuous while run_i.
module meas_sig_gen
    import meas_pkg::*;
#(
    parameter int unsigned T_CNT_WIDTH = SG_T_CNT_WIDTH,
    parameter int unsigned W_CNT_WIDTH = SG_W_CNT_WIDTH,
    parameter int unsigned B_CNT_WIDTH = SG_B_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [T_CNT_WIDTH-1:0] period_i,
    input  logic [W_CNT_WIDTH-1:0] width_i,
    input  logic [B_CNT_WIDTH-1:0] burst_len_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic                   run_i,
    output logic                   sig_o,
    output logic                   period_start_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    // Config held at this instance's widths.
    typedef struct packed {
        logic [T_CNT_WIDTH-1:0] period;
        logic [W_CNT_WIDTH-1:0] width;
    } cfg_t;

    // Common width for the zero-extended legality compare.
    localparam int unsigned CMP_WIDTH = (T_CNT_WIDTH > W_CNT_WIDTH) ? T_CNT_WIDTH : W_CNT_WIDTH;

    sg_state_e              state_q, state_d;
    logic [T_CNT_WIDTH-1:0] cnt_q, cnt_d;
    cfg_t                   shadow_q, shadow_d;
    logic                   shadow_full_q, shadow_full_d;
    cfg_t                   active_q, active_d;
    logic                   active_vld_q, active_vld_d;
    logic                   err_q, err_d;
    logic                   sig_q, sig_d;
    logic                   pstart_q, pstart_d;
    logic                   done_q, done_d;

    logic                   cfg_ok;
    logic                   xfer;
    logic                   load_active;
    logic [T_CNT_WIDTH-1:0] high_last_cnt;
    logic [T_CNT_WIDTH-1:0] period_last_cnt;
    logic                   high_last;
    logic                   period_last;
    logic                   boundary;
    logic                   start_run;
    logic                   restart;
    logic                   burst_done;
    logic                   hold;

    // Offered config legality and the handshake itself.
    always_comb begin
        cfg_ok = (CMP_WIDTH'(period_i) >= CMP_WIDTH'(SG_MIN_PERIOD))
              && (width_i != '0)
              && (CMP_WIDTH'(width_i) < CMP_WIDTH'(period_i));
        xfer   = cfg_valid_i && !shadow_full_q;
    end

    // Counter compare points derived from the active config.
    always_comb begin
        high_last_cnt   = T_CNT_WIDTH'(active_q.width) - T_CNT_WIDTH'(1);
        period_last_cnt = active_q.period - T_CNT_WIDTH'(1);
        high_last       = (cnt_q == high_last_cnt);
        period_last     = (cnt_q == period_last_cnt);
        boundary        = (state_q == SG_LOW) && period_last;
    end

    // FSM next state and single period counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_run = 1'b0;
        restart   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            SG_IDLE: begin
                cnt_d = '0;
                if (run_i && active_vld_q && !hold) begin
                    state_d   = SG_HIGH;
                    start_run = 1'b1;
                end
            end
            SG_HIGH: begin
                cnt_d = cnt_q + T_CNT_WIDTH'(1);
                if (high_last) begin
                    state_d = SG_LOW;
                end
            end
            SG_LOW: begin
                if (period_last) begin
                    cnt_d = '0;
                    if (run_i && !burst_done) begin
                        state_d = SG_HIGH;
                        restart = 1'b1;
                    end else begin
                        state_d = SG_IDLE;
                        done_d  = burst_done;
                    end
                end else begin
                    cnt_d = cnt_q + T_CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = SG_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow/active config handling; a load frees the shadow, a legal transfer fills it.
    // Transfers only happen with the shadow empty, so the two never collide.
    always_comb begin
        load_active   = shadow_full_q && ((state_q == SG_IDLE) || boundary);
        active_d      = load_active ? shadow_q : active_q;
        active_vld_d  = active_vld_q || load_active;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        err_d         = err_q;
        if (load_active) begin
            shadow_full_d = 1'b0;
        end
        if (xfer) begin
            if (cfg_ok) begin
                shadow_d.period = period_i;
                shadow_d.width  = width_i;
                shadow_full_d   = 1'b1;
                err_d           = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Output register: sig_o follows the FSM one cycle later, giving a clean flop output.
    always_comb begin
        sig_d    = (state_q == SG_HIGH);
        pstart_d = (state_q == SG_HIGH) && (cnt_q == '0);
    end

    // State, counter, config and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SG_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            active_q      <= '0;
            active_vld_q  <= 1'b0;
            err_q         <= 1'b0;
            sig_q         <= 1'b0;
            pstart_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            active_q      <= active_d;
            active_vld_q  <= active_vld_d;
            err_q         <= err_d;
            sig_q         <= sig_d;
            pstart_q      <= pstart_d;
            done_q        <= done_d;
        end
    end

`ifdef MEAS_SIG_GEN_BURST_EN
    logic [B_CNT_WIDTH-1:0] burst_len_q, burst_len_d;
    logic [B_CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic                   hold_q, hold_d;

    // Burst length latched at run start; pulse_cnt counts pulses begun in this run.
    always_comb begin
        burst_len_d = burst_len_q;
        pulse_cnt_d = pulse_cnt_q;
        if (start_run) begin
            burst_len_d = burst_len_i;
            pulse_cnt_d = B_CNT_WIDTH'(1);
        end else if (restart) begin
            pulse_cnt_d = pulse_cnt_q + B_CNT_WIDTH'(1);
        end
        burst_done = (burst_len_q != '0) && (pulse_cnt_q == burst_len_q);
        // After completion run_i must be seen low before another burst may start.
        hold_d     = done_d || (hold_q && run_i);
        hold       = hold_q;
    end

    // Burst bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_len_q <= '0;
            pulse_cnt_q <= '0;
            hold_q      <= 1'b0;
        end else begin
            burst_len_q <= burst_len_d;
            pulse_cnt_q <= pulse_cnt_d;
            hold_q      <= hold_d;
        end
    end
`else
    logic unused_burst;

    // Burst disabled: never completes, never holds off a restart.
    always_comb begin
        burst_done   = 1'b0;
        hold         = 1'b0;
        unused_burst = ^{burst_len_i, start_run, restart};
    end
`endif

    assign cfg_ready_o    = !shadow_full_q;
    assign sig_o          = sig_q;
    assign period_start_o = pstart_q;
    assign busy_o         = (state_q != SG_IDLE);
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_meas_sig_gen.sv
// tb_meas_sig_gen: directed self-checking bench for meas_sig_gen.
// Burst scenario is compiled only when MEAS_SIG_GEN_BURST_EN is defined.
module tb_meas_sig_gen;

    logic        clk;
    logic        rst;
    logic [31:0] period;
    logic [15:0] width;
    logic [15:0] burst_len;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        run;
    logic        sig;
    logic        pstart;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    meas_sig_gen dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .period_i       (period),
        .width_i        (width),
        .burst_len_i    (burst_len),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .run_i          (run),
        .sig_o          (sig),
        .period_start_o (pstart),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Offer one config for a single cycle; returns just after the transfer edge.
    task automatic offer(input logic [31:0] p, input logic [15:0] w);
        period = p;
        width = w;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        n_cmp++; if (sig !== 1'b0) begin n_err++; $display("FAIL reset_sig: got %b want 0", sig); end
        n_cmp++; if (pstart !== 1'b0) begin n_err++; $display("FAIL reset_pstart: got %b want 0", pstart); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        rst = 1'b0;
    endtask

    // P=2500, W=3: 3 high cycles, rising edges 2500 cycles apart, one start strobe each.
    task automatic test_basic();
        int hi, ps, dn;
        do_reset();
        offer(32'd2500, 16'd3);
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_after_xfer: got %b want 0", cfg_ready); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b want 0", err); end
        step();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after_load: got %b want 1", cfg_ready); end
        run = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_cmp++; if (sig !== 1'b0) begin n_err++; $display("FAIL basic_sig_latency: got %b want 0", sig); end
        step();
        hi = 0; ps = 0; dn = 0;
        for (int k = 0; k < 2500; k++) begin
            hi += int'(sig);
            ps += int'(pstart);
            dn += int'(done);
            step();
        end
        n_cmp++; if (hi != 3) begin n_err++; $display("FAIL basic_high_cycles: got %0d want 3", hi); end
        n_cmp++; if (ps != 1) begin n_err++; $display("FAIL basic_pstart_count: got %0d want 1", ps); end
        n_cmp++; if (dn != 0) begin n_err++; $display("FAIL basic_done_count: got %0d want 0", dn); end
        n_cmp++; if (sig !== 1'b1) begin n_err++; $display("FAIL basic_second_rise: got %b want 1", sig); end
        n_cmp++; if (pstart !== 1'b1) begin n_err++; $display("FAIL basic_second_pstart: got %b want 1", pstart); end
        run = 1'b0;
    endtask

    // Illegal configs raise err and leave the generator idle; a legal one clears err.
    task automatic test_invalid();
        do_reset();
        run = 1'b1;
        offer(32'd2500, 16'd0);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL inv_w0_err: got %b want 1", err); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL inv_w0_ready: got %b want 1", cfg_ready); end
        offer(32'd2500, 16'd2500);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL inv_weqp_err: got %b want 1", err); end
        offer(32'd1, 16'd1);
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL inv_p1_err: got %b want 1", err); end
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL inv_busy: got %b want 0", busy); end
        n_cmp++; if (sig !== 1'b0) begin n_err++; $display("FAIL inv_sig: got %b want 0", sig); end
        offer(32'd100, 16'd10);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL inv_valid_err: got %b want 0", err); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL inv_valid_ready: got %b want 0", cfg_ready); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL inv_busy_load: got %b want 0", busy); end
        step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL inv_busy_start: got %b want 1", busy); end
        step();
        n_cmp++; if (sig !== 1'b1) begin n_err++; $display("FAIL inv_sig_start: got %b want 1", sig); end
        run = 1'b0;
    endtask

    // New config offered mid-HIGH takes effect only at the next period boundary.
    task automatic test_reconfig();
        int hi_old, hi_new, ps_mid;
        do_reset();
        offer(32'd2500, 16'd3);
        step();
        run = 1'b1;
        step();
        step();  // k = 0: first rising cycle
        period = 32'd1000;
        width = 16'd5;
        cfg_valid = 1'b1;
        step();  // k = 1: transfer edge
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rcfg_ready_low: got %b want 0", cfg_ready); end
        hi_old = 1;
        for (int k = 1; k < 2499; k++) begin
            hi_old += int'(sig);
            step();
        end
        // k = 2499: boundary edge has just copied the shadow
        n_cmp++; if (hi_old != 3) begin n_err++; $display("FAIL rcfg_old_high: got %0d want 3", hi_old); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rcfg_ready_boundary: got %b want 1", cfg_ready); end
        n_cmp++; if (sig !== 1'b0) begin n_err++; $display("FAIL rcfg_sig_before_rise: got %b want 0", sig); end
        step();  // k = 2500
        n_cmp++; if (pstart !== 1'b1) begin n_err++; $display("FAIL rcfg_new_rise: got %b want 1", pstart); end
        hi_new = 0; ps_mid = 0;
        for (int k = 2500; k < 3500; k++) begin
            hi_new += int'(sig);
            ps_mid += int'(pstart);
            step();
        end
        n_cmp++; if (hi_new != 5) begin n_err++; $display("FAIL rcfg_new_high: got %0d want 5", hi_new); end
        n_cmp++; if (ps_mid != 1) begin n_err++; $display("FAIL rcfg_new_pstart: got %0d want 1", ps_mid); end
        n_cmp++; if (pstart !== 1'b1) begin n_err++; $display("FAIL rcfg_next_rise: got %b want 1", pstart); end
        run = 1'b0;
    endtask

    // run_i dropped 10 cycles into a P=100 period: period completes, then idle.
    task automatic test_stop();
        int hi;
        do_reset();
        offer(32'd100, 16'd10);
        step();
        run = 1'b1;
        step();
        step();  // k = 0
        for (int k = 0; k < 10; k++) step();
        run = 1'b0;  // k = 10
        for (int k = 10; k < 98; k++) step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_busy_k98: got %b want 1", busy); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy_k99: got %b want 0", busy); end
        hi = 0;
        for (int k = 0; k < 300; k++) begin
            hi += int'(sig);
            step();
        end
        n_cmp++; if (hi != 0) begin n_err++; $display("FAIL stop_no_pulses: got %0d want 0", hi); end
    endtask

    // Reset mid-HIGH clears outputs and both configs; run_i ignored until reloaded.
    task automatic test_reset_mid();
        do_reset();
        offer(32'd100, 16'd10);
        step();
        run = 1'b1;
        step();
        step();
        step();
        n_cmp++; if (sig !== 1'b1) begin n_err++; $display("FAIL rmid_sig_before: got %b want 1", sig); end
        rst = 1'b1;
        step();
        n_cmp++; if (sig !== 1'b0) begin n_err++; $display("FAIL rmid_sig: got %b want 0", sig); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", cfg_ready); end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_run_ignored: got %b want 0", busy); end
        offer(32'd50, 16'd5);
        step();
        step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_restart: got %b want 1", busy); end
        run = 1'b0;
    endtask

`ifdef MEAS_SIG_GEN_BURST_EN
    // Burst of 5 pulses at P=50, W=2 with run_i held high throughout.
    task automatic test_burst();
        int ps, dn;
        do_reset();
        burst_len = 16'd5;
        offer(32'd50, 16'd2);
        step();
        run = 1'b1;
        ps = 0; dn = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            ps += int'(pstart);
            dn += int'(done);
        end
        n_cmp++; if (ps != 5) begin n_err++; $display("FAIL burst_pulses: got %0d want 5", ps); end
        n_cmp++; if (dn != 1) begin n_err++; $display("FAIL burst_done: got %0d want 1", dn); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy: got %b want 0", busy); end
        run = 1'b0;
        burst_len = 16'd0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        period = '0;
        width = '0;
        burst_len = '0;
        cfg_valid = 1'b0;
        run = 1'b0;
        test_reset();
        test_basic();
        test_invalid();
        test_reconfig();
        test_stop();
        test_reset_mid();
`ifdef MEAS_SIG_GEN_BURST_EN
        test_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
